// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with independent horizontal/vertical counters.
// Every output is a register decoded from next-state counters, so all fields describe one pixel.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0,
  parameter int unsigned CW     = 10,
  parameter int unsigned FCW    = 16
) (
  input  logic           pixelClk,
  input  logic           locked,
  input  logic           en,
  output logic           hSync,
  output logic           vSync,
  output logic           hVis,
  output logic           vVis,
  output logic           de,
  output logic [CW-1:0]  xCor,
  output logic [CW-1:0]  yCor,
  output logic           lineStart,
  output logic           frameStart,
  output logic [FCW-1:0] frameCount
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // Inclusive region bounds keep every constant representable in CW bits.
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOT - 1);
  localparam logic [CW-1:0] H_VIS_LAST  = CW'(H_VIS - 1);
  localparam logic [CW-1:0] H_SYNC_FST  = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOT - 1);
  localparam logic [CW-1:0] V_VIS_LAST  = CW'(V_VIS - 1);
  localparam logic [CW-1:0] V_SYNC_FST  = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_VIS + V_FP + V_SYNC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  x_q, x_d;
  logic [CW-1:0]  y_q, y_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           hvis_q, hvis_d;
  logic           vvis_q, vvis_d;
  logic           de_q, de_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic           load_c;

  // Next-state counters, then output decode of the pixel those counters will show.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    load_c  = 1'b0;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    hvis_d  = hvis_q;
    vvis_d  = vvis_q;
    de_d    = de_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          fc_d    = fc_q + FCW'(1);
          ls_d    = 1'b1;
          fs_d    = 1'b1;
          load_c  = 1'b1;
        end
      end
      ST_RUN: begin
        if (en) begin
          load_c = 1'b1;
          if (x_q == H_LAST) begin
            x_d  = '0;
            ls_d = 1'b1;
            if (y_q == V_LAST) begin
              y_d  = '0;
              fc_d = fc_q + FCW'(1);
              fs_d = 1'b1;
            end else begin
              y_d = y_q + CW'(1);
            end
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      hvis_d  = (x_d <= H_VIS_LAST);
      vvis_d  = (y_d <= V_VIS_LAST);
      de_d    = hvis_d & vvis_d;
      hsync_d = ((x_d >= H_SYNC_FST) && (x_d <= H_SYNC_LAST)) ? H_POL : ~H_POL;
      vsync_d = ((y_d >= V_SYNC_FST) && (y_d <= V_SYNC_LAST)) ? V_POL : ~V_POL;
    end
  end

  // Loss of PLL lock returns everything to idle values immediately.
  always_ff @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      hvis_q  <= 1'b0;
      vvis_q  <= 1'b0;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hvis_q  <= hvis_d;
      vvis_q  <= vvis_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign hVis       = hvis_q;
  assign vVis       = vvis_q;
  assign de         = de_q;
  assign xCor       = x_q;
  assign yCor       = y_q;
  assign lineStart  = ls_q;
  assign frameStart = fs_q;
  assign frameCount = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x525 mode and a 14x8 active-high override.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default-mode instance
  logic        d_locked, d_en;
  logic        d_hs, d_vs, d_hv, d_vv, d_de, d_ls, d_fs;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;

  vga_timing_gen u_def (
    .pixelClk(clk), .locked(d_locked), .en(d_en),
    .hSync(d_hs), .vSync(d_vs), .hVis(d_hv), .vVis(d_vv), .de(d_de),
    .xCor(d_x), .yCor(d_y), .lineStart(d_ls), .frameStart(d_fs), .frameCount(d_fc)
  );

  // Small override instance: 14 x 8, active-high syncs, 4-bit frame counter
  logic       s_locked, s_en;
  logic       s_hs, s_vs, s_hv, s_vv, s_de, s_ls, s_fs;
  logic [3:0] s_x, s_y;
  logic [3:0] s_fc;

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FCW(4)
  ) u_sml (
    .pixelClk(clk), .locked(s_locked), .en(s_en),
    .hSync(s_hs), .vSync(s_vs), .hVis(s_hv), .vVis(s_vv), .de(s_de),
    .xCor(s_x), .yCor(s_y), .lineStart(s_ls), .frameStart(s_fs), .frameCount(s_fc)
  );

  // Reference pixel position, frame count and expected strobes
  int dx, dy, dfc, sx, sy, sfc;
  int d_ls_e, d_fs_e, s_ls_e, s_fs_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_def(input logic enabled);
    d_ls_e = 0;
    d_fs_e = 0;
    if (enabled) begin
      dx++;
      if (dx == 800) begin
        dx = 0;
        dy++;
        if (dy == 525) begin
          dy = 0;
          dfc++;
        end
      end
      d_ls_e = (dx == 0);
      d_fs_e = (dx == 0 && dy == 0);
    end
  endtask

  task automatic adv_sml(input logic enabled);
    s_ls_e = 0;
    s_fs_e = 0;
    if (enabled) begin
      sx++;
      if (sx == 14) begin
        sx = 0;
        sy++;
        if (sy == 8) begin
          sy = 0;
          sfc++;
        end
      end
      s_ls_e = (sx == 0);
      s_fs_e = (sx == 0 && sy == 0);
    end
  endtask

  task automatic chk_def_idle();
    chk("d_idle_x", d_x, 0);   chk("d_idle_y", d_y, 0);   chk("d_idle_fc", d_fc, 0);
    chk("d_idle_hv", d_hv, 0); chk("d_idle_vv", d_vv, 0); chk("d_idle_de", d_de, 0);
    chk("d_idle_ls", d_ls, 0); chk("d_idle_fs", d_fs, 0);
    chk("d_idle_hs", d_hs, 1); chk("d_idle_vs", d_vs, 1);
  endtask

  task automatic chk_sml_idle();
    chk("s_idle_x", s_x, 0);   chk("s_idle_y", s_y, 0);   chk("s_idle_fc", s_fc, 0);
    chk("s_idle_de", s_de, 0); chk("s_idle_ls", s_ls, 0); chk("s_idle_fs", s_fs, 0);
    chk("s_idle_hs", s_hs, 0); chk("s_idle_vs", s_vs, 0);
  endtask

  task automatic chk_def();
    chk("d_x", d_x, dx);
    chk("d_y", d_y, dy);
    chk("d_fc", d_fc, dfc % 65536);
    chk("d_hs", d_hs, (dx >= 656 && dx <= 751) ? 0 : 1);
    chk("d_vs", d_vs, (dy >= 490 && dy <= 491) ? 0 : 1);
    chk("d_hv", d_hv, (dx < 640) ? 1 : 0);
    chk("d_vv", d_vv, (dy < 480) ? 1 : 0);
    chk("d_de", d_de, (dx < 640 && dy < 480) ? 1 : 0);
    chk("d_ls", d_ls, d_ls_e);
    chk("d_fs", d_fs, d_fs_e);
  endtask

  task automatic chk_sml();
    chk("s_x", s_x, sx);
    chk("s_y", s_y, sy);
    chk("s_fc", s_fc, sfc % 16);
    chk("s_hs", s_hs, (sx >= 10 && sx <= 12) ? 1 : 0);
    chk("s_vs", s_vs, (sy >= 5 && sy <= 6) ? 1 : 0);
    chk("s_de", s_de, (sx < 8 && sy < 4) ? 1 : 0);
    chk("s_ls", s_ls, s_ls_e);
    chk("s_fs", s_fs, s_fs_e);
  endtask

  initial begin
    int hs_low, ls_cnt, vs_hi, cyc, last_fs;
    logic prev_ls, prev_fs;

    d_locked = 1'b0; d_en = 1'b0;
    s_locked = 1'b0; s_en = 1'b0;

    // Held in reset while en toggles: idle values only
    repeat (4) begin
      d_en = ~d_en;
      s_en = ~s_en;
      tick();
      chk_def_idle();
      chk_sml_idle();
    end

    // Default mode: first enabled edge after release
    d_locked = 1'b1;
    d_en     = 1'b1;
    tick();
    dx = 0; dy = 0; dfc = 1; d_ls_e = 1; d_fs_e = 1;
    chk_def();

    // Two full lines at en=1
    hs_low = 0;
    ls_cnt = 0;
    for (int i = 0; i < 1650; i++) begin
      tick();
      adv_def(1'b1);
      chk_def();
      if (dy == 0 && d_hs == 1'b0) hs_low++;
      if (d_ls) ls_cnt++;
    end
    chk("d_hs_low_count", hs_low, 96);
    chk("d_ls_count", ls_cnt, 2);

    // Pseudo-random enable: outputs hold, strobes never stretch
    prev_ls = d_ls;
    prev_fs = d_fs;
    for (int i = 0; i < 2000; i++) begin
      d_en = 1'($urandom_range(0, 1));
      tick();
      adv_def(d_en);
      chk_def();
      chk("d_ls_single", d_ls & prev_ls, 0);
      chk("d_fs_single", d_fs & prev_fs, 0);
      prev_ls = d_ls;
      prev_fs = d_fs;
    end

    // Lock lost mid-frame: asynchronous return to idle values
    d_en = 1'b1;
    d_locked = 1'b0;
    #2;
    chk_def_idle();
    tick();
    chk_def_idle();
    d_locked = 1'b1;
    tick();
    dx = 0; dy = 0; dfc = 1; d_ls_e = 1; d_fs_e = 1;
    chk_def();
    for (int i = 0; i < 20; i++) begin
      tick();
      adv_def(1'b1);
      chk_def();
    end
    d_locked = 1'b0;

    // Small mode: 18 frames at en=1 covers period, sync windows and counter wrap
    s_locked = 1'b1;
    s_en     = 1'b1;
    tick();
    sx = 0; sy = 0; sfc = 1; s_ls_e = 1; s_fs_e = 1;
    chk_sml();
    cyc = 0;
    last_fs = 0;
    vs_hi = 0;
    hs_low = 0;
    for (int i = 0; i < 18 * 112; i++) begin
      tick();
      cyc++;
      adv_sml(1'b1);
      chk_sml();
      if (sfc == 1 && s_vs) vs_hi++;
      if (sfc == 1 && sy == 0 && s_hs) hs_low++;
      if (s_fs) begin
        chk("s_frame_period", cyc - last_fs, 112);
        last_fs = cyc;
      end
    end
    chk("s_vs_high_count", vs_hi, 28);
    chk("s_hs_high_count", hs_low, 3);
    chk("s_fc_after_wrap", s_fc, 4'd3);

    // Small mode with random enable
    prev_ls = s_ls;
    for (int i = 0; i < 500; i++) begin
      s_en = 1'($urandom_range(0, 1));
      tick();
      adv_sml(s_en);
      chk_sml();
      chk("s_ls_single", s_ls & prev_ls, 0);
      prev_ls = s_ls;
    end

    // Run to (6,3), drop lock, then restart from (0,0)
    s_en = 1'b1;
    for (int i = 0; i < 200 && !(sx == 6 && sy == 3); i++) begin
      tick();
      adv_sml(1'b1);
      chk_sml();
    end
    chk("s_reach_6_3", (s_x == 4'd6 && s_y == 4'd3) ? 1 : 0, 1);
    s_locked = 1'b0;
    #2;
    chk_sml_idle();
    tick();
    s_locked = 1'b1;
    tick();
    sx = 0; sy = 0; sfc = 1; s_ls_e = 1; s_fs_e = 1;
    chk_sml();
    for (int i = 0; i < 30; i++) begin
      tick();
      adv_sml(1'b1);
      chk_sml();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
